// File: rtl/mem_arbiter_if.sv
// Pipeline-side handshakes, vector delivery and the single memory port of mem_arbiter.
// The master modport is the pipeline/memory side; slave is the arbiter.
interface mem_arbiter_if;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_gnt;
  logic       if_valid;
  logic [7:0] if_data;
  logic       dm_rd;
  logic       dm_wr;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdata;
  logic       dm_gnt;
  logic       dm_valid;
  logic [7:0] dm_rdata;
  logic       int_req;
  logic       vec_valid;
  logic       vec_type;
  logic [7:0] vec_data;
  logic       busy;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, int_req, mem_rdata,
    input  if_gnt, if_valid, if_data, dm_gnt, dm_valid, dm_rdata,
           vec_valid, vec_type, vec_data, busy,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, int_req, mem_rdata,
    output if_gnt, if_valid, if_data, dm_gnt, dm_valid, dm_rdata,
           vec_valid, vec_type, vec_data, busy,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data beats fetch, fetch starvation bounded by STARVE_MAX,
// reset/interrupt vector reads. Grants are combinational; responses follow 1 cycle later.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, IVEC} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic       int_pend;
  logic       dm_req;
  logic       fetch_win;
  logic       vec_cycle;

  assign dm_req    = bus.dm_rd | bus.dm_wr;
  assign fetch_win = bus.if_req & (~dm_req | (starve_cnt == SMAX));
  assign vec_cycle = (state == BOOT) | (state == IVEC);

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      IVEC:    state_nxt = RUN;
      RUN:     if (bus.int_req || int_pend) state_nxt = IVEC;
      default: state_nxt = BOOT;
    endcase
  end

  // Everything combinational is forced quiet while reset is held.
  always_comb begin
    bus.if_gnt      = 1'b0;
    bus.dm_gnt      = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = 8'h00;
    bus.mem_wdata   = 8'h00;
    bus.busy        = 1'b0;
    if (!reset) begin
      case (state)
        BOOT: begin
          bus.busy     = 1'b1;
          bus.mem_read = 1'b1;
        end
        IVEC: begin
          bus.busy        = 1'b1;
          bus.mem_read    = 1'b1;
          bus.mem_address = 8'h01;
        end
        RUN: begin
          if (fetch_win) begin
            bus.if_gnt      = 1'b1;
            bus.mem_read    = 1'b1;
            bus.mem_address = bus.if_addr;
          end else if (dm_req) begin
            bus.dm_gnt      = 1'b1;
            bus.mem_address = bus.dm_addr;
            if (bus.dm_wr) begin
              bus.mem_write = 1'b1;
              bus.mem_wdata = bus.dm_wdata;
            end else begin
              bus.mem_read = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.if_valid  <= 1'b0;
      bus.if_data   <= 8'h00;
      bus.dm_valid  <= 1'b0;
      bus.dm_rdata  <= 8'h00;
      bus.vec_valid <= 1'b0;
      bus.vec_type  <= 1'b0;
      bus.vec_data  <= 8'h00;
      starve_cnt    <= 4'd0;
      int_pend      <= 1'b0;
    end else begin
      bus.if_valid  <= bus.if_gnt;
      bus.dm_valid  <= bus.dm_gnt;
      bus.vec_valid <= vec_cycle;
      if (bus.if_gnt) bus.if_data <= bus.mem_rdata;
      if (bus.dm_gnt && !bus.dm_wr) bus.dm_rdata <= bus.mem_rdata;
      if (vec_cycle) begin
        bus.vec_type <= (state == IVEC);
        bus.vec_data <= bus.mem_rdata;
      end
      // Counts consecutive lost cycles; frozen while a vector is being read.
      if (state == RUN) begin
        if (bus.if_req && !bus.if_gnt) begin
          if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          starve_cnt <= 4'd0;
        end
      end
      if (vec_cycle && bus.int_req)                   int_pend <= 1'b1;
      else if (state == RUN && state_nxt == IVEC)     int_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run checked against a cycle-level reference model.
module tb_mem_arbiter;
  localparam int SMAX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_pass = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_address];
  always @(posedge clk) if (bus.mem_write === 1'b1) mem[bus.mem_address] = bus.mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0; bus.if_addr = 8'h00;
    bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = 8'h00; bus.dm_wdata = 8'h00;
    bus.int_req = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.if_req = 1'b1; bus.dm_rd = 1'b1; bus.dm_addr = 8'h33;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (bus.if_gnt !== 1'b0) $display("FAIL rst_if_gnt got %b exp 0", bus.if_gnt); else n_pass++;
    n_checks++; if (bus.dm_gnt !== 1'b0) $display("FAIL rst_dm_gnt got %b exp 0", bus.dm_gnt); else n_pass++;
    n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL rst_mem_read got %b exp 0", bus.mem_read); else n_pass++;
    n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL rst_mem_write got %b exp 0", bus.mem_write); else n_pass++;
    n_checks++; if (bus.mem_address !== 8'h00) $display("FAIL rst_mem_address got %h exp 00", bus.mem_address); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.vec_valid !== 1'b0) $display("FAIL rst_vec_valid got %b exp 0", bus.vec_valid); else n_pass++;
    n_checks++; if (bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0) $display("FAIL rst_valids got %b%b exp 00", bus.if_valid, bus.dm_valid); else n_pass++;
    n_checks++; if (bus.vec_data !== 8'h00 || bus.if_data !== 8'h00 || bus.dm_rdata !== 8'h00) $display("FAIL rst_data got %h %h %h exp 00", bus.vec_data, bus.if_data, bus.dm_rdata); else n_pass++;
    idle();
  endtask

  task automatic test_boot();
    mem[8'h00] = 8'h10;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 8'h00) $display("FAIL boot_port got rd=%b a=%h exp rd=1 a=00", bus.mem_read, bus.mem_address); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL boot_busy got %b exp 1", bus.busy); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.vec_valid !== 1'b1 || bus.vec_type !== 1'b0 || bus.vec_data !== 8'h10) $display("FAIL boot_vec got v=%b t=%b d=%h exp v=1 t=0 d=10", bus.vec_valid, bus.vec_type, bus.vec_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0) $display("FAIL boot_done got busy=%b rd=%b exp 0 0", bus.busy, bus.mem_read); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.vec_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL boot_pulse got v=%b busy=%b exp 0 0", bus.vec_valid, bus.busy); else n_pass++;
  endtask

  task automatic test_fetch();
    mem[8'h10] = 8'hC0;
    tick(); idle();
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    @(negedge clk);
    n_checks++; if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) $display("FAIL fetch_gnt got if=%b dm=%b exp 1 0", bus.if_gnt, bus.dm_gnt); else n_pass++;
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 8'h10) $display("FAIL fetch_port got rd=%b a=%h exp 1 10", bus.mem_read, bus.mem_address); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_data !== 8'hC0) $display("FAIL fetch_resp got v=%b d=%h exp 1 c0", bus.if_valid, bus.if_data); else n_pass++;
    n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_address !== 8'h00 || bus.mem_wdata !== 8'h00) $display("FAIL fetch_idle got rd=%b a=%h w=%h exp 0 00 00", bus.mem_read, bus.mem_address, bus.mem_wdata); else n_pass++;
  endtask

  task automatic test_write_read();
    tick(); idle();
    bus.dm_wr = 1'b1; bus.dm_addr = 8'h40; bus.dm_wdata = 8'h5A;
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    @(negedge clk);
    n_checks++; if (bus.dm_gnt !== 1'b1 || bus.if_gnt !== 1'b0) $display("FAIL wr_gnt got dm=%b if=%b exp 1 0", bus.dm_gnt, bus.if_gnt); else n_pass++;
    n_checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 8'h40 || bus.mem_wdata !== 8'h5A) $display("FAIL wr_port got wr=%b rd=%b a=%h w=%h exp 1 0 40 5a", bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_wdata); else n_pass++;
    tick();
    bus.dm_wr = 1'b0; bus.dm_rd = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.dm_gnt !== 1'b1 || bus.dm_valid !== 1'b1) $display("FAIL rd_gnt got gnt=%b wr_valid=%b exp 1 1", bus.dm_gnt, bus.dm_valid); else n_pass++;
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) $display("FAIL rd_port got rd=%b wr=%b exp 1 0", bus.mem_read, bus.mem_write); else n_pass++;
    tick();
    bus.dm_rd = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== 8'h5A) $display("FAIL rd_resp got v=%b d=%h exp 1 5a", bus.dm_valid, bus.dm_rdata); else n_pass++;
    n_checks++; if (bus.if_gnt !== 1'b1) $display("FAIL wr_fetch_gnt got %b exp 1", bus.if_gnt); else n_pass++;
    tick(); idle();
    @(negedge clk);
    n_checks++; if (bus.if_valid !== 1'b1 || bus.if_data !== 8'hC0 || bus.dm_valid !== 1'b0) $display("FAIL wr_fetch_resp got v=%b d=%h dmv=%b exp 1 c0 0", bus.if_valid, bus.if_data, bus.dm_valid); else n_pass++;
  endtask

  task automatic test_starvation();
    tick(); idle();
    bus.dm_rd = 1'b1; bus.dm_addr = 8'h40;
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    for (int i = 0; i < SMAX; i++) begin
      @(negedge clk);
      n_checks++; if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b1) $display("FAIL starve_lose%0d got if=%b dm=%b exp 0 1", i, bus.if_gnt, bus.dm_gnt); else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++; if (bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) $display("FAIL starve_win got if=%b dm=%b exp 1 0", bus.if_gnt, bus.dm_gnt); else n_pass++;
    tick();
    bus.if_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.dm_gnt !== 1'b1 || bus.if_valid !== 1'b1 || bus.if_data !== 8'hC0) $display("FAIL starve_resume got dm=%b ifv=%b d=%h exp 1 1 c0", bus.dm_gnt, bus.if_valid, bus.if_data); else n_pass++;
  endtask

  task automatic test_interrupt();
    mem[8'h01] = 8'h80;
    tick(); idle();
    bus.int_req = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL int_run_busy got %b exp 0", bus.busy); else n_pass++;
    tick();
    bus.int_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 8'h10;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_address !== 8'h01) $display("FAIL ivec_port got busy=%b rd=%b a=%h exp 1 1 01", bus.busy, bus.mem_read, bus.mem_address); else n_pass++;
    n_checks++; if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0) $display("FAIL ivec_nogrant got if=%b dm=%b exp 0 0", bus.if_gnt, bus.dm_gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.vec_valid !== 1'b1 || bus.vec_type !== 1'b1 || bus.vec_data !== 8'h80) $display("FAIL ivec_vec got v=%b t=%b d=%h exp 1 1 80", bus.vec_valid, bus.vec_type, bus.vec_data); else n_pass++;
    n_checks++; if (bus.if_gnt !== 1'b1 || bus.busy !== 1'b0) $display("FAIL ivec_after got if=%b busy=%b exp 1 0", bus.if_gnt, bus.busy); else n_pass++;
  endtask

  task automatic test_boot_int();
    tick(); idle();
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.int_req = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.mem_address !== 8'h00 || bus.mem_read !== 1'b1) $display("FAIL bint_boot got busy=%b a=%h rd=%b exp 1 00 1", bus.busy, bus.mem_address, bus.mem_read); else n_pass++;
    tick();
    bus.int_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.vec_valid !== 1'b1 || bus.vec_type !== 1'b0 || bus.busy !== 1'b0) $display("FAIL bint_run got v=%b t=%b busy=%b exp 1 0 0", bus.vec_valid, bus.vec_type, bus.busy); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.mem_address !== 8'h01) $display("FAIL bint_ivec got busy=%b a=%h exp 1 01", bus.busy, bus.mem_address); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.vec_valid !== 1'b1 || bus.vec_type !== 1'b1 || bus.vec_data !== 8'h80) $display("FAIL bint_vec got v=%b t=%b d=%h exp 1 1 80", bus.vec_valid, bus.vec_type, bus.vec_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(); idle();
    bus.int_req = 1'b1;
    tick();
    bus.int_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL rmid_in_ivec got busy=%b exp 1", bus.busy); else n_pass++;
    reset = 1'b1;
    tick();
    bus.int_req = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.vec_valid !== 1'b0 || bus.vec_type !== 1'b0 || bus.vec_data !== 8'h00) $display("FAIL rmid_vec got v=%b t=%b d=%h exp 0 0 00", bus.vec_valid, bus.vec_type, bus.vec_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0) $display("FAIL rmid_quiet got busy=%b rd=%b ifv=%b dmv=%b exp 0 0 0 0", bus.busy, bus.mem_read, bus.if_valid, bus.dm_valid); else n_pass++;
    tick();
    reset = 1'b0; bus.int_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_address !== 8'h00) $display("FAIL rmid_boot got busy=%b rd=%b a=%h exp 1 1 00", bus.busy, bus.mem_read, bus.mem_address); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.vec_valid !== 1'b1 || bus.vec_type !== 1'b0 || bus.vec_data !== 8'h10) $display("FAIL rmid_vec0 got v=%b t=%b d=%h exp 1 0 10", bus.vec_valid, bus.vec_type, bus.vec_data); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rmid_no_pend got busy=%b exp 0", bus.busy); else n_pass++;
  endtask

  // Reference: each cycle is either a vector read (svc 0 = reset, 1 = interrupt) or an
  // arbitration cycle; 'losses' is how many cycles in a row the waiting fetch has lost.
  task automatic test_random();
    logic [7:0] ref_mem [256];
    int         svc, losses, r;
    bit         pend, run, dreq, fg, dg;
    bit         e_ifv, e_dmv, e_vv, e_vt, x_rd, x_wr;
    logic [7:0] e_ifd, e_dmd, e_vd, x_a, x_w;
    tick(); idle();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    tick(); tick();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    e_ifv = 0; e_dmv = 0; e_vv = 0; e_vt = 0; e_ifd = 0; e_dmd = 0; e_vd = 0;
    svc = 0; pend = 0; losses = 0;
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      run  = (svc < 0);
      dreq = bus.dm_rd | bus.dm_wr;
      fg   = run && bus.if_req && (!dreq || losses == SMAX);
      dg   = run && dreq && !fg;
      x_rd = !run || fg || (dg && !bus.dm_wr);
      x_wr = dg && bus.dm_wr;
      x_a  = !run ? 8'(svc) : fg ? bus.if_addr : dg ? bus.dm_addr : 8'h00;
      x_w  = x_wr ? bus.dm_wdata : 8'h00;
      n_checks++; if (bus.if_gnt !== fg || bus.dm_gnt !== dg) $display("FAIL rnd_gnt c%0d got if=%b dm=%b exp %b %b", cyc, bus.if_gnt, bus.dm_gnt, fg, dg); else n_pass++;
      n_checks++; if (bus.mem_read !== x_rd || bus.mem_write !== x_wr) $display("FAIL rnd_rw c%0d got rd=%b wr=%b exp %b %b", cyc, bus.mem_read, bus.mem_write, x_rd, x_wr); else n_pass++;
      n_checks++; if (bus.mem_address !== x_a || bus.mem_wdata !== x_w) $display("FAIL rnd_addr c%0d got a=%h w=%h exp %h %h", cyc, bus.mem_address, bus.mem_wdata, x_a, x_w); else n_pass++;
      n_checks++; if (bus.busy !== !run) $display("FAIL rnd_busy c%0d got %b exp %b", cyc, bus.busy, !run); else n_pass++;
      n_checks++; if (bus.if_valid !== e_ifv || bus.if_data !== e_ifd) $display("FAIL rnd_if c%0d got v=%b d=%h exp %b %h", cyc, bus.if_valid, bus.if_data, e_ifv, e_ifd); else n_pass++;
      n_checks++; if (bus.dm_valid !== e_dmv || bus.dm_rdata !== e_dmd) $display("FAIL rnd_dm c%0d got v=%b d=%h exp %b %h", cyc, bus.dm_valid, bus.dm_rdata, e_dmv, e_dmd); else n_pass++;
      n_checks++; if (bus.vec_valid !== e_vv || bus.vec_type !== e_vt || bus.vec_data !== e_vd) $display("FAIL rnd_vec c%0d got v=%b t=%b d=%h exp %b %b %h", cyc, bus.vec_valid, bus.vec_type, bus.vec_data, e_vv, e_vt, e_vd); else n_pass++;
      e_ifv = fg;
      e_dmv = dg;
      e_vv  = !run;
      if (fg) e_ifd = ref_mem[bus.if_addr];
      if (dg && !bus.dm_wr) e_dmd = ref_mem[bus.dm_addr];
      if (!run) begin e_vt = (svc == 1); e_vd = ref_mem[8'(svc)]; end
      if (x_wr) ref_mem[bus.dm_addr] = bus.dm_wdata;
      if (run) losses = (bus.if_req && !fg) ? ((losses < SMAX) ? losses + 1 : SMAX) : 0;
      if (!run) begin
        if (bus.int_req) pend = 1;
        svc = -1;
      end else if (bus.int_req || pend) begin
        svc = 1;
        pend = 0;
      end
      tick();
      if (!(bus.if_req && !fg)) begin
        bus.if_req  = ($urandom_range(0, 2) == 0);
        bus.if_addr = 8'($urandom_range(0, 15));
      end
      if (!(dreq && !dg)) begin
        r = $urandom_range(0, 7);
        bus.dm_rd    = (r == 0 || r == 1 || r == 4);
        bus.dm_wr    = (r == 2 || r == 3 || r == 4);
        bus.dm_addr  = 8'($urandom_range(0, 15));
        bus.dm_wdata = 8'($urandom);
      end
      bus.int_req = !bus.int_req && ($urandom_range(0, 19) == 0);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_boot();
    test_fetch();
    test_write_read();
    test_starvation();
    test_interrupt();
    test_boot_int();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port access arbiter and vector sequencer in front of the 256×8 unified (Von Neumann) memory. It multiplexes the fetch stage and the memory stage of the pipeline onto the one memory port: data accesses have priority, and fetches have bounded starvation. After reset it reads the reset vector at address 0x00. On an interrupt it reads the interrupt vector at address 0x01, and it hands each vector to the PC logic.

## Interface
- STARVE_MAX, default 4: maximum number of consecutive RUN cycles a pending fetch may lose to data accesses; range 1–15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (level; held until if_gnt)
- if_addr  in  8  fetch address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_valid  out  1  fetch data valid (registered, 1-cycle pulse)
- if_data  out  8  fetched byte
- dm_rd  in  1  data read request (held until dm_gnt)
- dm_wr  in  1  data write request (held until dm_gnt)
- dm_addr  in  8  data address
- dm_wdata  in  8  write data
- dm_gnt  out  1  data access granted this cycle (combinational)
- dm_valid  out  1  data access completed (registered pulse, reads and writes)
- dm_rdata  out  8  read data
- int_req  in  1  interrupt request, single-cycle pulse
- vec_valid  out  1  vector byte valid (registered pulse)
- vec_type  out  1  0 = reset vector, 1 = interrupt vector
- vec_data  out  8  vector byte
- busy  out  1  high in BOOT and IVEC
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_address  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data (asynchronous)

## Operation
- States:
  - BOOT: entered on reset. Drives mem_read=1 and mem_address=0x00, with no grants. Captures vec_data and sets vec_type=0, then moves to RUN.
  - RUN: normal arbitration.
  - IVEC: drives mem_read=1 and mem_address=0x01, with no grants. Captures vec_data and sets vec_type=1, then returns to RUN.
- RUN → IVEC when int_req=1 or int_pend=1. Grants issued in that RUN cycle still complete normally.
- int_pend is set by int_req arriving in BOOT or IVEC. It is cleared on entry to IVEC.
- Arbitration in RUN:
  - Any data request (dm_rd or dm_wr) wins over if_req, unless starve_cnt == STARVE_MAX. In that case fetch is granted and data waits.
  - dm_wr and dm_rd both high: the write is performed; the read is ignored for that grant.
- Memory port drive:
  - Granted read: mem_read=1, with the address from the winner.
  - Granted write: mem_write=1, mem_wdata=dm_wdata.
  - Idle: mem_read, mem_write, mem_address and mem_wdata are all 0.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, on each RUN cycle with if_req=1 and if_gnt=0.
  - Clears on if_gnt or if_req=0.
  - Frozen in BOOT and IVEC.
- Response capture at the edge ending the grant cycle:
  - if_data ← mem_rdata.
  - dm_rdata ← mem_rdata for reads only.
  - if_data, dm_rdata and vec_data hold their values between updates.
- The arbiter never issues more than one memory access per cycle.

## Timing
- Reset values:
  - All outputs are 0.
  - State is BOOT.
  - starve_cnt and int_pend are 0.
- During reset high: no memory access and no grants.
- The first cycle with reset low is BOOT. vec_valid is high in the following cycle.
- Grant is combinational, in the same cycle as the request. if_valid or dm_valid is asserted exactly 1 cycle after the grant, for 1 cycle.
- A write commits at the same edge that ends its grant cycle. A read of the same address granted in the next cycle returns the new value.
- IVEC lasts 1 cycle. vec_valid is asserted the cycle after IVEC. The PC logic must not issue a fetch it depends on before then.
- Reset asserted in any state aborts the operation:
  - Returns to BOOT.
  - Discards pending int_pend.
  - Drops in-flight valids to 0 at the next edge.

## Test plan
1. **Boot vector:** preload mem[0x00]=0x10, release reset → BOOT cycle shows mem_read=1 and mem_address=0x00; next cycle vec_valid=1, vec_type=0, vec_data=0x10; busy=0 from then on.
2. **Plain fetch:** if_req=1, if_addr=0x10, mem[0x10]=0xC0 → if_gnt=1 in the same cycle; next cycle if_valid=1, if_data=0xC0.
3. **Write then read with fetch contention:** dm_wr, dm_addr=0x40, dm_wdata=0x5A, with if_req=1 → dm_gnt=1 and if_gnt=0. Then dm_rd 0x40 → dm_valid=1 and dm_rdata=0x5A one cycle after that grant.
4. **Fetch starvation:** STARVE_MAX=4, dm_rd held high continuously with if_req=1 → if_gnt=0 for 4 cycles, if_gnt=1 on the 5th cycle (dm_gnt=0 there), then dm_gnt resumes.
5. **Interrupt vector:** mem[0x01]=0x80, int_req pulse in RUN → next cycle IVEC with mem_address=0x01 and no grants; following cycle vec_valid=1, vec_type=1, vec_data=0x80. An int_req pulse during BOOT is deferred and serviced in IVEC right after the first RUN cycle.
6. **Reset mid-operation:** reset asserted during IVEC → all outputs 0 next cycle, no vec_valid with vec_type=1; after release, the boot sequence of scenario 1 repeats.
